multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 69 ++++++
 rtl/op_classifier.sv | 41 ++++
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/funct
// values, datapath select codes, instruction classes and the control bundle.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] SRC_IMM = 2'd0;
  localparam logic [1:0] SRC_PC  = 2'd1;
  localparam logic [1:0] SRC_DB  = 2'd2;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  typedef enum logic [3:0] {
    C_ADD, C_SLT, C_ADDI, C_ADDIU, C_LW, C_SW,
    C_BEQ, C_BNE, C_JAL, C_JR, C_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic       ir_wr;
    logic       pc_wr;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       extend;
    logic [1:0] pc_src;
    logic [1:0] alu_src;
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
  } ctrl_t;

  // R-type results land in rd; every other write-back class targets rt.
  function automatic logic is_rtype_alu(input iclass_t c);
    return (c == C_ADD) || (c == C_SLT);
  endfunction

endpackage

// File: rtl/op_classifier.sv
// Combinational instruction classifier: opcode (and funct for opcode 0)
// mapped to an instruction class; anything unsupported is C_ILLEGAL.
import mc_pkg::*;

module op_classifier (
  input  logic [31:0] instruction,
  output iclass_t     cls
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign unused_fields = ^instruction[25:6];

  // NOTE: a default assignment before the case keeps this block latch-free.
  always_comb begin
    cls = C_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: cls = C_ADD;
          FN_SLT:          cls = C_SLT;
          FN_JR:           cls = C_JR;
          default:         cls = C_ILLEGAL;
        endcase
      end
      OP_ADDI:  cls = C_ADDI;
      OP_ADDIU: cls = C_ADDIU;
      OP_LW:    cls = C_LW;
      OP_SW:    cls = C_SW;
      OP_BEQ:   cls = C_BEQ;
      OP_BNE:   cls = C_BNE;
      OP_JAL:   cls = C_JAL;
      default:  cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with Moore output decode and retired counter.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap unsupported instructions.
import mc_pkg::*;

module multicycle_control #(
  parameter int RET_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IRWr,
  output logic             PCWr,
  output logic             RegWr,
  output logic             MemRd,
  output logic             MemWr,
  output logic             MemToReg,
  output logic             ExtendMethod,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUsrc,
  output logic [1:0]       RegDst,
  output logic [2:0]       ALUcntrl,
  output logic [2:0]       state,
  output logic [RET_W-1:0] retired,
  output logic             illegal
);

  state_t  st;
  iclass_t cls_dec;
  iclass_t cls_q;
  logic    done;
  ctrl_t   c;

  op_classifier u_classifier (
    .instruction (instruction),
    .cls         (cls_dec)
  );

  // High on the last cycle of any instruction that completes normally.
  always_comb begin
    done = 1'b0;
    case (st)
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
      S_DECODE: done = (cls_dec == C_ILLEGAL);
`endif
      S_EXEC:   done = (cls_q == C_BEQ) || (cls_q == C_BNE) ||
                       (cls_q == C_JAL) || (cls_q == C_JR);
      S_MEM:    done = mem_ready && (cls_q == C_SW);
      S_WB:     done = 1'b1;
      default:  done = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_FETCH;
      cls_q   <= C_ILLEGAL;
      retired <= '0;
    end else begin
      if (done) retired <= retired + RET_W'(1);
      case (st)
        S_FETCH: st <= S_DECODE;
        S_DECODE: begin
          cls_q <= cls_dec;
          if (cls_dec == C_ILLEGAL) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            st <= S_TRAP;
`else
            st <= S_FETCH;
`endif
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_LW, C_SW:                   st <= S_MEM;
            C_ADD, C_SLT, C_ADDI, C_ADDIU: st <= S_WB;
            default:                      st <= S_FETCH;
          endcase
        end
        S_MEM:   if (mem_ready) st <= (cls_q == C_LW) ? S_WB : S_FETCH;
        S_WB:    st <= S_FETCH;
        S_TRAP:  st <= S_TRAP;
        default: st <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, even though FETCH is held.
  always_comb begin
    c = '0;
    if (rst_n) begin
      case (st)
        S_FETCH: begin
          c.ir_wr  = 1'b1;
          c.pc_wr  = 1'b1;
          c.pc_src = PC_PLUS4;
        end
        S_EXEC: begin
          case (cls_q)
            C_ADD: c.alu_src = SRC_DB;
            C_SLT: begin
              c.alu_op  = ALU_SLT;
              c.alu_src = SRC_DB;
            end
            C_ADDI, C_LW, C_SW: c.alu_src = SRC_IMM;
            C_ADDIU: begin
              c.alu_src = SRC_IMM;
              c.extend  = 1'b1;
            end
            C_BEQ, C_BNE: begin
              c.alu_op  = ALU_SUB;
              c.alu_src = SRC_DB;
              c.pc_src  = PC_BRANCH;
              c.pc_wr   = (cls_q == C_BEQ) ? zero : !zero;
            end
            C_JAL: begin
              c.reg_wr  = 1'b1;
              c.reg_dst = DST_RA;
              c.alu_src = SRC_PC;
              c.pc_wr   = 1'b1;
              c.pc_src  = PC_JUMP;
            end
            C_JR: begin
              c.pc_wr  = 1'b1;
              c.pc_src = PC_REG;
            end
            default: c = '0;
          endcase
        end
        S_MEM: begin
          c.mem_rd = (cls_q == C_LW);
          c.mem_wr = (cls_q == C_SW);
        end
        S_WB: begin
          c.reg_wr     = 1'b1;
          c.reg_dst    = is_rtype_alu(cls_q) ? DST_RD : DST_RT;
          c.mem_to_reg = (cls_q == C_LW);
        end
        default: c = '0;
      endcase
    end
  end

  assign IRWr         = c.ir_wr;
  assign PCWr         = c.pc_wr;
  assign RegWr        = c.reg_wr;
  assign MemRd        = c.mem_rd;
  assign MemWr        = c.mem_wr;
  assign MemToReg     = c.mem_to_reg;
  assign ExtendMethod = c.extend;
  assign PCSrc        = c.pc_src;
  assign ALUsrc       = c.alu_src;
  assign RegDst       = c.reg_dst;
  assign ALUcntrl     = c.alu_op;
  assign state        = st;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal = (st == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (RET_W=4): per-cycle state and
// control checks for each instruction class, reset abort and counter wrap.
module tb_multicycle_control;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   instruction = 32'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          IRWr, PCWr, RegWr, MemRd, MemWr, MemToReg, ExtendMethod;
  logic [1:0]    PCSrc, ALUsrc, RegDst;
  logic [2:0]    ALUcntrl;
  logic [2:0]    state;
  logic [RW-1:0] retired;
  logic          illegal;

  int n_pass  = 0;
  int n_total = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_control #(.RET_W(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .IRWr         (IRWr),
    .PCWr         (PCWr),
    .RegWr        (RegWr),
    .MemRd        (MemRd),
    .MemWr        (MemWr),
    .MemToReg     (MemToReg),
    .ExtendMethod (ExtendMethod),
    .PCSrc        (PCSrc),
    .ALUsrc       (ALUsrc),
    .RegDst       (RegDst),
    .ALUcntrl     (ALUcntrl),
    .state        (state),
    .retired      (retired),
    .illegal      (illegal)
  );

  wire [15:0] ctl = {IRWr, PCWr, RegWr, MemRd, MemWr, MemToReg, ExtendMethod,
                     PCSrc, ALUsrc, RegDst, ALUcntrl};

  function automatic logic [15:0] cv(
    input logic irwr, pcwr, regwr, memrd, memwr, m2r, ext,
    input logic [1:0] pcsrc, alusrc, regdst,
    input logic [2:0] alu
  );
    return {irwr, pcwr, regwr, memrd, memwr, m2r, ext, pcsrc, alusrc, regdst, alu};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [15:0] c);
    check({tag, " state"}, {29'd0, state}, {29'd0, st});
    check({tag, " ctl"}, {16'd0, ctl}, {16'd0, c});
  endtask

  task automatic expect_ret(input string tag);
    check({tag, " retired"}, {28'd0, retired}, exp_ret);
  endtask

  // Starts mid-cycle in FETCH; returns mid-cycle in the state after DECODE.
  task automatic fetch_decode(input string tag, input logic [31:0] ins);
    instruction = ins;
    #1;
    expect_cycle({tag, " fetch"}, 3'd0, cv(1,1,0,0,0,0,0, 2'd0,2'd0,2'd0,3'd0));
    tick();
    expect_cycle({tag, " decode"}, 3'd1, 16'd0);
    tick();
  endtask

  localparam logic [31:0] I_ADD   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_SLT   = {6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h2A};
  localparam logic [31:0] I_JR    = {6'h00, 5'd31, 15'd0, 6'h08};
  localparam logic [31:0] I_BEQ   = {6'h04, 26'd3};
  localparam logic [31:0] I_BNE   = {6'h05, 26'd3};
  localparam logic [31:0] I_JAL   = {6'h03, 26'h10};
  localparam logic [31:0] I_LW    = {6'h23, 26'd4};
  localparam logic [31:0] I_SW    = {6'h2B, 26'd8};
  localparam logic [31:0] I_ADDIU = {6'h09, 26'd5};
  localparam logic [31:0] I_BAD   = {6'h3F, 26'd0};

  initial begin
    // Reset held: FETCH, everything low.
    #12;
    expect_cycle("reset", 3'd0, 16'd0);
    expect_ret("reset");
    check("reset illegal", {31'd0, illegal}, 32'd0);

    // add: F D E WB, RegWr only on cycle 4.
    @(negedge clk);
    rst_n = 1'b1;
    fetch_decode("add", I_ADD);
    expect_cycle("add exec", 3'd2, cv(0,0,0,0,0,0,0, 2'd0,2'd2,2'd0,3'd0));
    tick();
    expect_cycle("add wb", 3'd4, cv(0,0,1,0,0,0,0, 2'd0,2'd0,2'd1,3'd0));
    expect_ret("add wb");
    tick();
    exp_ret = 1;
    expect_ret("add done");
    check("add back to fetch", {29'd0, state}, 32'd0);

    // beq taken.
    fetch_decode("beq", I_BEQ);
    zero = 1'b1;
    #1;
    expect_cycle("beq exec z1", 3'd2, cv(0,1,0,0,0,0,0, 2'd1,2'd2,2'd0,3'd1));
    tick();
    zero = 1'b0;
    exp_ret = 2;
    expect_ret("beq done");

    // bne with zero=1 then zero=0 in the same EXEC cycle.
    fetch_decode("bne", I_BNE);
    zero = 1'b1;
    #1;
    expect_cycle("bne exec z1", 3'd2, cv(0,0,0,0,0,0,0, 2'd1,2'd2,2'd0,3'd1));
    zero = 1'b0;
    #1;
    check("bne exec z0 PCWr", {31'd0, PCWr}, 32'd1);
    tick();
    exp_ret = 3;
    expect_ret("bne done");
    check("bne back to fetch", {29'd0, state}, 32'd0);

    // jal and jr.
    fetch_decode("jal", I_JAL);
    expect_cycle("jal exec", 3'd2, cv(0,1,1,0,0,0,0, 2'd2,2'd1,2'd2,3'd0));
    tick();
    exp_ret = 4;
    expect_ret("jal done");
    fetch_decode("jr", I_JR);
    expect_cycle("jr exec", 3'd2, cv(0,1,0,0,0,0,0, 2'd3,2'd0,2'd0,3'd0));
    tick();
    exp_ret = 5;
    expect_ret("jr done");

    // lw with 3 wait cycles; mem_ready during EXEC must be ignored.
    fetch_decode("lw", I_LW);
    mem_ready = 1'b1;
    #1;
    expect_cycle("lw exec", 3'd2, 16'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    expect_cycle("lw mem1", 3'd3, cv(0,0,0,1,0,0,0, 2'd0,2'd0,2'd0,3'd0));
    tick();
    expect_cycle("lw mem2", 3'd3, cv(0,0,0,1,0,0,0, 2'd0,2'd0,2'd0,3'd0));
    tick();
    expect_cycle("lw mem3", 3'd3, cv(0,0,0,1,0,0,0, 2'd0,2'd0,2'd0,3'd0));
    tick();
    mem_ready = 1'b1;
    #1;
    expect_cycle("lw mem4", 3'd3, cv(0,0,0,1,0,0,0, 2'd0,2'd0,2'd0,3'd0));
    tick();
    mem_ready = 1'b0;
    #1;
    expect_cycle("lw wb", 3'd4, cv(0,0,1,0,0,1,0, 2'd0,2'd0,2'd0,3'd0));
    expect_ret("lw wb");
    tick();
    exp_ret = 6;
    expect_ret("lw done");

    // addiu and slt.
    fetch_decode("addiu", I_ADDIU);
    expect_cycle("addiu exec", 3'd2, cv(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,3'd0));
    tick();
    expect_cycle("addiu wb", 3'd4, cv(0,0,1,0,0,0,0, 2'd0,2'd0,2'd0,3'd0));
    tick();
    exp_ret = 7;
    expect_ret("addiu done");
    fetch_decode("slt", I_SLT);
    expect_cycle("slt exec", 3'd2, cv(0,0,0,0,0,0,0, 2'd0,2'd2,2'd0,3'd3));
    tick();
    expect_cycle("slt wb", 3'd4, cv(0,0,1,0,0,0,0, 2'd0,2'd0,2'd1,3'd0));
    tick();
    exp_ret = 8;
    expect_ret("slt done");

    // sw aborted by reset during the MEM wait.
    fetch_decode("sw", I_SW);
    expect_cycle("sw exec", 3'd2, 16'd0);
    tick();
    expect_cycle("sw mem", 3'd3, cv(0,0,0,0,1,0,0, 2'd0,2'd0,2'd0,3'd0));
    rst_n = 1'b0;
    #1;
    exp_ret = 0;
    expect_cycle("sw abort", 3'd0, 16'd0);
    expect_ret("sw abort");
    @(negedge clk);
    rst_n = 1'b1;

    // sw completing after one MEM cycle.
    fetch_decode("sw2", I_SW);
    tick();
    mem_ready = 1'b1;
    #1;
    expect_cycle("sw2 mem", 3'd3, cv(0,0,0,0,1,0,0, 2'd0,2'd0,2'd0,3'd0));
    tick();
    mem_ready = 1'b0;
    exp_ret = 1;
    expect_ret("sw2 done");
    check("sw2 back to fetch", {29'd0, state}, 32'd0);

    // Unsupported opcode.
    fetch_decode("bad", I_BAD);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    expect_cycle("bad trap", 3'd5, 16'd0);
    check("bad illegal", {31'd0, illegal}, 32'd1);
    tick();
    tick();
    tick();
    expect_cycle("bad trap held", 3'd5, 16'd0);
    expect_ret("bad trap held");
`else
    exp_ret = 2;
    expect_cycle("bad nop", 3'd0, cv(1,1,0,0,0,0,0, 2'd0,2'd0,2'd0,3'd0));
    expect_ret("bad nop");
    check("bad illegal", {31'd0, illegal}, 32'd0);
`endif

    // Counter wrap with 16 beq instructions.
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0;
    instruction = I_BEQ;
    for (int i = 0; i < 16; i++) begin
      tick();
      tick();
      tick();
      exp_ret = (exp_ret + 1) % 16;
      if (i == 14) expect_ret("wrap 15");
    end
    expect_ret("wrap 0");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
